// File: rtl/uart_pkg.sv
// Shared definitions for the ROM-to-UART streamer and other tx_uart users:
// FSM state encoding and the default UART configuration byte.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_CONFIG = 3'd0,
      ST_IDLE   = 3'd1,
      ST_FETCH  = 3'd2,
      ST_SEND   = 3'd3,
      ST_GAP    = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERROR  = 3'd6
   } state_e;

   // Divider setting for 115200 baud on the low-speed clock.
   localparam logic [7:0] BAUD_CFG_115200 = 8'h0B;

   function automatic logic is_active(input state_e s);
      return (s == ST_FETCH) || (s == ST_SEND) || (s == ST_GAP);
   endfunction

endpackage

// File: rtl/gap_timer.sv
// Inter-byte spacing timer: enforces a minimum idle period after each UART
// write and, optionally, also waits for the UART to report it is no longer busy.
module gap_timer #(
   parameter int GAP_CYCLES = 871,
   parameter int USE_BUSY   = 1
) (
   input  logic w_clk_low,
   input  logic rst,
   input  logic load,
   input  logic count,
   input  logic tx_busy,
   output logic expired
);

   localparam int CNT_W = $clog2(GAP_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(GAP_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Saturates so a long busy-wait can never wrap back below the threshold.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (count && (cnt_q != CNT_SAT)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge w_clk_low) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = count && (cnt_q >= CNT_LAST) && ((USE_BUSY == 0) || !tx_busy);

endmodule

// File: rtl/rom_uart_streamer.sv
// Streams a fixed-length message from a combinational ROM into a UART,
// configuring the UART baud rate once after every reset.
module rom_uart_streamer
   import uart_pkg::*;
#(
   parameter int          MSG_LEN    = 16,
   parameter int          ADDR_W     = 4,
   parameter logic [7:0]  BAUD_CFG   = BAUD_CFG_115200,
   parameter int          GAP_CYCLES = 871,
   parameter int          CONTINUOUS = 0,
   parameter int          USE_BUSY   = 1
) (
   input  logic              w_clk_low,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_data,
   input  logic              mem_illegal,
   output logic [7:0]        cfg_data,
   output logic              cfg_enable,
   output logic [7:0]        tx_data,
   output logic              tx_write,
   input  logic              tx_busy,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              stop_q, stop_d;
   logic              gap_load;
   logic              gap_count;
   logic              gap_expired;

   gap_timer #(
      .GAP_CYCLES (GAP_CYCLES),
      .USE_BUSY   (USE_BUSY)
   ) u_gap_timer (
      .w_clk_low (w_clk_low),
      .rst       (rst),
      .load      (gap_load),
      .count     (gap_count),
      .tx_busy   (tx_busy),
      .expired   (gap_expired)
   );

   always_ff @(posedge w_clk_low) begin
      if (rst) begin
         state_q   <= ST_CONFIG;
         addr_q    <= '0;
         tx_data_q <= '0;
         stop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         tx_data_q <= tx_data_d;
         stop_q    <= stop_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      tx_data_d = tx_data_q;
      stop_d    = stop_q;
      gap_load  = 1'b0;
      gap_count = 1'b0;
      case (state_q)
         ST_CONFIG: state_d = ST_IDLE;
         ST_IDLE: begin
            stop_d = 1'b0;
            if (start && !stop) begin
               addr_d  = '0;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            stop_d = stop_q | stop;
            if (mem_illegal) begin
               state_d = ST_ERROR;
            end else begin
               tx_data_d = mem_data;
               state_d   = ST_SEND;
            end
         end
         ST_SEND: begin
            stop_d   = stop_q | stop;
            gap_load = 1'b1;
            state_d  = ST_GAP;
         end
         ST_GAP: begin
            stop_d    = stop_q | stop;
            gap_count = 1'b1;
            if (gap_expired) begin
               // A stop abandons the rest of the message, so it never reaches DONE.
               addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
               if (stop_q || stop) begin
                  state_d = ST_IDLE;
               end else if (addr_q != LAST_ADDR) begin
                  state_d = ST_FETCH;
               end else if (CONTINUOUS != 0) begin
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         ST_ERROR: state_d = ST_ERROR;
         default:  state_d = ST_CONFIG;
      endcase
   end

   // Strobes are masked by rst so a held reset can never leak a pulse.
   assign mem_addr   = addr_q;
   assign tx_data    = tx_data_q;
   assign tx_write   = (state_q == ST_SEND) && !rst;
   assign cfg_enable = (state_q == ST_CONFIG) && !rst;
   assign cfg_data   = cfg_enable ? BAUD_CFG : 8'h00;
   assign done       = (state_q == ST_DONE) && !rst;
   assign error      = (state_q == ST_ERROR) && !rst;
   assign busy       = is_active(state_q);

endmodule

// File: doc/rom_uart_streamer.md
ROM_UART_STREAMER -- requirements
Module: rom_uart_streamer

Interface
REQ-001 Parameter MSG_LEN, default 16: bytes per message (2..256).
REQ-002 Parameter ADDR_W, default 4: memory address width; SHALL satisfy 2^ADDR_W >= MSG_LEN.
REQ-003 Parameter BAUD_CFG, default 8'h0B: config byte written to the UART after reset (115200 baud).
REQ-004 Parameter GAP_CYCLES, default 871: minimum idle cycles after each write pulse.
REQ-005 Parameter CONTINUOUS, default 0: 0 = one-shot message, 1 = loop until stop.
REQ-006 Parameter USE_BUSY, default 1: 1 = additionally wait for tx_busy low before the next byte.
REQ-007 w_clk_low  in  1  clock; reset rst, synchronous, active-high; clock w_clk_low.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 start  in  1  begin a message; sampled in IDLE only.
REQ-010 stop  in  1  abort request; honoured at the next byte boundary.
REQ-011 mem_addr  out  ADDR_W  ROM address; ROM is combinational.
REQ-012 mem_data  in  8  ROM byte at mem_addr, same cycle.
REQ-013 mem_illegal  in  1  ROM flags mem_addr as invalid.
REQ-014 cfg_data / cfg_enable  out  8 / 1  UART config byte and one-cycle strobe.
REQ-015 tx_data / tx_write  out  8 / 1  UART byte and one-cycle write strobe.
REQ-016 tx_busy  in  1  UART shifting a byte.
REQ-017 busy / done / error  out  1 each  message active / one-cycle completion pulse / sticky ROM fault.

Function
REQ-018 FSM states SHALL be CONFIG, IDLE, FETCH, SEND, GAP, DONE, ERROR.
REQ-019 CONFIG: one cycle with cfg_enable=1, cfg_data=BAUD_CFG; next state IDLE.
REQ-020 IDLE: start=1 and stop=0 -> FETCH with address 0; start and stop together -> remain IDLE.
REQ-021 FETCH: mem_addr=current address; if mem_illegal=1 -> ERROR, else latch mem_data into tx_data and -> SEND.
REQ-022 SEND: tx_write=1 for exactly one cycle; -> GAP with gap counter cleared.
REQ-023 GAP SHALL last at least GAP_CYCLES cycles and, if USE_BUSY=1, until tx_busy=0 also; total start-of-FETCH to start-of-next-FETCH >= GAP_CYCLES+2.
REQ-024 GAP exit, address != MSG_LEN-1: increment address -> FETCH (or IDLE if stop was latched).
REQ-025 GAP exit, address == MSG_LEN-1: address wraps to 0; CONTINUOUS=1 and no stop -> FETCH; otherwise -> DONE.
REQ-026 DONE: done=1 for one cycle -> IDLE; an aborted (stop) message SHALL NOT pulse done.
REQ-027 stop pulse in FETCH/SEND/GAP SHALL be latched; the current byte completes including its gap.
REQ-028 ERROR: error=1 sticky, tx_write=0; leaves only on rst.
REQ-029 busy=1 in FETCH, SEND, GAP; 0 otherwise.
REQ-030 Gap counter width SHALL be $clog2(GAP_CYCLES+1) and SHALL saturate, never wrap.
REQ-031 tx_data SHALL hold its value outside SEND.

Reset
REQ-032 On rst: state CONFIG, address 0, tx_data 0, tx_write 0, cfg_enable 0, cfg_data 0, done 0, error 0, stop latch 0, gap counter 0.
REQ-033 rst mid-message SHALL abandon the byte without a write strobe; CONFIG reissues on the first cycle after rst falls.
REQ-034 rst held SHALL keep all strobes low.

Structure
REQ-035 State encoding and default BAUD_CFG SHALL live in shared package uart_pkg, reused by tx_uart users.
REQ-036 The gap/busy wait SHALL be sub-module gap_timer (load, count, expired), the only sub-module.

Verification
REQ-037 Reset release -> cfg_enable=1 exactly one cycle, cfg_data=8'h0B, then IDLE, busy=0.
REQ-038 MSG_LEN=4, GAP_CYCLES=10, USE_BUSY=0, start pulse -> 4 tx_write pulses, bytes ROM[0..3], consecutive strobes 12 cycles apart, done one cycle after final gap.
REQ-039 USE_BUSY=1, tx_busy held high 50 cycles after first write -> second tx_write no earlier than tx_busy fall + 1 cycle.
REQ-040 CONTINUOUS=1, MSG_LEN=4 -> address sequence 0,1,2,3,0,1; stop during byte 1 -> byte 1 completes, IDLE, no done.
REQ-041 mem_illegal=1 at address 2 -> exactly 2 writes, error=1 sticky, no further strobes until rst.
REQ-042 rst during GAP of byte 1 -> no further write, cfg_enable pulse after release, fresh start resends from ROM[0].
